// File: rtl/i2c_pkg.sv
// Shared constants for the I2C FIFO bank: status_reg bit positions, reset value, default depth.
package i2c_pkg;
    localparam int ST_TX_FULL  = 7;
    localparam int ST_TX_EMPTY = 6;
    localparam int ST_RX_FULL  = 5;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_TX_UDF   = 1;
    localparam int ST_RX_UDF   = 0;

    localparam logic [7:0] ST_RESET = 8'b0101_0000;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock byte FIFO with registered read data and one-cycle overflow/underflow event pulses.
module i2c_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wdata,
    input  logic          rd_en,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf
);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0] r_count;
    logic [7:0]  r_rdata;
    logic        w_push;
    logic        w_pop;

    assign full  = (r_count == LP_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_rdata;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && (!full || w_pop);
    assign ovf    = wr_en && !w_push;
    assign udf    = rd_en && empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= 8'h00;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_rdata <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/i2c_fifo_bank.sv
// TX/RX byte FIFOs between the APB slave and I2C master, plus the packed status register.
module i2c_fifo_bank
    import i2c_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          tx_wr_en,
    input  logic [7:0]    tx_wdata,
    input  logic          tx_rd_en,
    output logic [7:0]    tx_rdata,
    input  logic          rx_wr_en,
    input  logic [7:0]    rx_wdata,
    input  logic          rx_rd_en,
    output logic [7:0]    rx_rdata,
    input  logic          err_clr,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic [7:0]    status_reg
);
    logic       w_tx_full, w_tx_empty, w_tx_ovf, w_tx_udf;
    logic       w_rx_full, w_rx_empty, w_rx_ovf, w_rx_udf;
    logic [3:0] w_evt;
    logic [3:0] r_err;

    i2c_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET),
        .wr_en(tx_wr_en), .wdata(tx_wdata),
        .rd_en(tx_rd_en), .rdata(tx_rdata),
        .count(tx_count), .full(w_tx_full), .empty(w_tx_empty),
        .ovf(w_tx_ovf), .udf(w_tx_udf)
    );

    i2c_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET),
        .wr_en(rx_wr_en), .wdata(rx_wdata),
        .rd_en(rx_rd_en), .rdata(rx_rdata),
        .count(rx_count), .full(w_rx_full), .empty(w_rx_empty),
        .ovf(w_rx_ovf), .udf(w_rx_udf)
    );

    // Ordered to match status_reg[3:0]; a fresh event overrides a coincident clear.
    assign w_evt = {w_tx_ovf, w_rx_ovf, w_tx_udf, w_rx_udf};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_err <= 4'b0000;
        end else begin
            r_err <= w_evt | (r_err & {4{~err_clr}});
        end
    end

    always_comb begin
        status_reg              = 8'h00;
        status_reg[ST_TX_FULL]  = w_tx_full;
        status_reg[ST_TX_EMPTY] = w_tx_empty;
        status_reg[ST_RX_FULL]  = w_rx_full;
        status_reg[ST_RX_EMPTY] = w_rx_empty;
        status_reg[ST_TX_OVF]   = r_err[3];
        status_reg[ST_RX_OVF]   = r_err[2];
        status_reg[ST_TX_UDF]   = r_err[1];
        status_reg[ST_RX_UDF]   = r_err[0];
    end
endmodule

// File: tb/tb_i2c_fifo_bank.sv
// Directed bench for i2c_fifo_bank: reset, fill/drain, wrap, simultaneous push/pop, errors.
module tb_i2c_fifo_bank;
    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       tx_wr_en = 1'b0, tx_rd_en = 1'b0;
    logic       rx_wr_en = 1'b0, rx_rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] tx_wdata = 8'h00, rx_wdata = 8'h00;
    logic [7:0] tx_rdata, rx_rdata, status_reg;
    logic [3:0] tx_count, rx_count;

    int checks = 0;
    int errors = 0;

    i2c_fifo_bank #(.DEPTH(8), .AW(3)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_rd_en(tx_rd_en), .tx_rdata(tx_rdata),
        .rx_wr_en(rx_wr_en), .rx_wdata(rx_wdata), .rx_rd_en(rx_rd_en), .rx_rdata(rx_rdata),
        .err_clr(err_clr), .tx_count(tx_count), .rx_count(rx_count), .status_reg(status_reg)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle;
        tx_wr_en = 0; tx_rd_en = 0; rx_wr_en = 0; rx_rd_en = 0; err_clr = 0; PRESET = 0;
    endtask

    task automatic test_reset;
        PRESET = 1; tick; tick; PRESET = 0;
        checks++; if (status_reg !== 8'h50) begin errors++; $display("FAIL reset_status got %h exp 50", status_reg); end
        checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL reset_tx_count got %0d exp 0", tx_count); end
        checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
        checks++; if (tx_rdata !== 8'h00 || rx_rdata !== 8'h00) begin errors++;
            $display("FAIL reset_rdata got tx=%h rx=%h exp 00", tx_rdata, rx_rdata); end
    endtask

    task automatic test_fill_tx;
        for (int i = 0; i < 8; i++) begin
            tx_wr_en = 1; tx_wdata = 8'hA0 + 8'(i); tick;
        end
        tx_wr_en = 0;
        checks++; if (tx_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", tx_count); end
        checks++; if (status_reg !== 8'h90) begin errors++; $display("FAIL fill_status got %h exp 90", status_reg); end
        tx_wr_en = 1; tx_wdata = 8'hFF; tick; tx_wr_en = 0;
        checks++; if (status_reg !== 8'h98) begin errors++; $display("FAIL ovf_status got %h exp 98", status_reg); end
        checks++; if (tx_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", tx_count); end
        for (int i = 0; i < 8; i++) begin
            tx_rd_en = 1; tick;
            checks++; if (tx_rdata !== 8'hA0 + 8'(i)) begin errors++;
                $display("FAIL drain_data[%0d] got %h exp %h", i, tx_rdata, 8'hA0 + 8'(i)); end
        end
        tx_rd_en = 0; tick;
        checks++; if (tx_rdata !== 8'hA7) begin errors++; $display("FAIL rdata_hold got %h exp a7", tx_rdata); end
        checks++; if (status_reg !== 8'h58) begin errors++; $display("FAIL drained_status got %h exp 58", status_reg); end
        err_clr = 1; tick; err_clr = 0;
        checks++; if (status_reg !== 8'h50) begin errors++; $display("FAIL clr_ovf got %h exp 50", status_reg); end
    endtask

    task automatic test_wrap;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                rx_wr_en = 1; rx_wdata = 8'(16 * r + 16 + i); tick;
            end
            rx_wr_en = 0;
            checks++; if (rx_count !== 4'd5) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 5", r, rx_count); end
            for (int i = 0; i < 5; i++) begin
                rx_rd_en = 1; tick;
                checks++; if (rx_rdata !== 8'(16 * r + 16 + i)) begin errors++;
                    $display("FAIL wrap_data[%0d][%0d] got %h exp %h", r, i, rx_rdata, 8'(16 * r + 16 + i)); end
            end
            rx_rd_en = 0;
        end
        checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", rx_count); end
        checks++; if (status_reg[4] !== 1'b1) begin errors++; $display("FAIL wrap_rx_empty got %b exp 1", status_reg[4]); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 8; i++) begin
            tx_wr_en = 1; tx_wdata = 8'hB0 + 8'(i); tick;
        end
        tx_wr_en = 1; tx_wdata = 8'h55; tx_rd_en = 1; tick; tx_wr_en = 0; tx_rd_en = 0;
        checks++; if (tx_count !== 4'd8) begin errors++; $display("FAIL simul_full_count got %0d exp 8", tx_count); end
        checks++; if (tx_rdata !== 8'hB0) begin errors++; $display("FAIL simul_full_data got %h exp b0", tx_rdata); end
        checks++; if (status_reg[3] !== 1'b0) begin errors++; $display("FAIL simul_full_no_ovf got %b exp 0", status_reg[3]); end
        for (int i = 1; i < 9; i++) begin
            tx_rd_en = 1; tick;
            checks++; if (tx_rdata !== ((i == 8) ? 8'h55 : 8'hB0 + 8'(i))) begin errors++;
                $display("FAIL simul_drain[%0d] got %h exp %h", i, tx_rdata, (i == 8) ? 8'h55 : 8'hB0 + 8'(i)); end
        end
        tx_rd_en = 0;
        // RX is empty here; last RX byte popped was 8'h34.
        rx_wr_en = 1; rx_wdata = 8'h77; rx_rd_en = 1; tick; rx_wr_en = 0; rx_rd_en = 0;
        checks++; if (rx_count !== 4'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", rx_count); end
        checks++; if (status_reg !== 8'h41) begin errors++; $display("FAIL simul_empty_status got %h exp 41", status_reg); end
        checks++; if (rx_rdata !== 8'h34) begin errors++; $display("FAIL simul_empty_hold got %h exp 34", rx_rdata); end
        rx_rd_en = 1; tick; rx_rd_en = 0;
        checks++; if (rx_rdata !== 8'h77) begin errors++; $display("FAIL simul_empty_data got %h exp 77", rx_rdata); end
        err_clr = 1; tick; err_clr = 0;
        checks++; if (status_reg !== 8'h50) begin errors++; $display("FAIL simul_clr got %h exp 50", status_reg); end
    endtask

    task automatic test_errors;
        rx_rd_en = 1; tick; rx_rd_en = 0;
        checks++; if (status_reg[0] !== 1'b1) begin errors++; $display("FAIL udf_set got %b exp 1", status_reg[0]); end
        tick;
        checks++; if (status_reg[0] !== 1'b1) begin errors++; $display("FAIL udf_sticky got %b exp 1", status_reg[0]); end
        err_clr = 1; tick; err_clr = 0;
        checks++; if (status_reg[0] !== 1'b0) begin errors++; $display("FAIL udf_clear got %b exp 0", status_reg[0]); end
        err_clr = 1; rx_rd_en = 1; tick; err_clr = 0; rx_rd_en = 0;
        checks++; if (status_reg[0] !== 1'b1) begin errors++; $display("FAIL udf_clr_race got %b exp 1", status_reg[0]); end
        checks++; if (status_reg[1] !== 1'b0) begin errors++; $display("FAIL tx_udf_indep got %b exp 0", status_reg[1]); end
        err_clr = 1; tick; err_clr = 0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            tx_wr_en = 1; tx_wdata = 8'hC0 + 8'(i); tick;
        end
        tx_wr_en = 0; rx_rd_en = 1; tick; rx_rd_en = 0;
        checks++; if (tx_count !== 4'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", tx_count); end
        PRESET = 1; tick; PRESET = 0;
        checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", tx_count); end
        checks++; if (status_reg !== 8'h50) begin errors++; $display("FAIL mid_status got %h exp 50", status_reg); end
        tx_rd_en = 1; tick; tx_rd_en = 0;
        checks++; if (tx_rdata !== 8'h00) begin errors++; $display("FAIL mid_pop_rdata got %h exp 00", tx_rdata); end
        checks++; if (status_reg !== 8'h52) begin errors++; $display("FAIL mid_pop_status got %h exp 52", status_reg); end
    endtask

    initial begin
        idle;
        tick;
        test_reset;
        test_fill_tx;
        test_wrap;
        test_simultaneous;
        test_errors;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
